// File: rtl/multi_pulse_window_detect.sv
// ---------------------------------------------------------------------------
// multi_pulse_window_detect
//
// Purpose:
//   Multi-channel x/y pulse window detector. Each channel raises p_o when it
//   sees an x pulse, then Y_TARGET y pulses (MODE 0: exactly, MODE 1: at
//   least), then another x pulse. p_o is registered. It rises one clock after
//   the closing x and falls one clock after the next y pulse on that channel.
//   Channels are fully independent.
//
// Parameters:
//   NUM_CH   - number of channels (>=1)
//   Y_TARGET - y pulses required between two x pulses (>=1)
//   MODE     - 0 = exact count, 1 = at-least count
//
// Ports:
//   clk       - clock
//   reset     - asynchronous, active-high reset
//   x_i       - per-channel x pulse
//   y_i       - per-channel y pulse
//   clr_i     - per-channel synchronous clear (highest priority)
//   p_o       - per-channel registered detect flag
//   hit_cnt_o - per-channel 8-bit saturating hit count, channel n at
//               [8n+7:8n] (only with MULTI_PULSE_HIT_CNT_EN)
//
// Configuration macro:
//   MULTI_PULSE_HIT_CNT_EN - adds the per-channel hit counters and hit_cnt_o.
// ---------------------------------------------------------------------------
module multi_pulse_window_detect #(
    parameter int NUM_CH   = 4,
    parameter int Y_TARGET = 2,
    parameter int MODE     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     x_i,
    input  logic [NUM_CH-1:0]     y_i,
    input  logic [NUM_CH-1:0]     clr_i,
`ifdef MULTI_PULSE_HIT_CNT_EN
    output logic [8*NUM_CH-1:0]   hit_cnt_o,
`endif
    output logic [NUM_CH-1:0]     p_o
);

    localparam int CNT_W = $clog2(Y_TARGET + 2);
    // SAT means "more than Y_TARGET y pulses seen"; the counter never wraps,
    // so an overlong window can never alias back onto a match.
    localparam logic [CNT_W-1:0] SAT = CNT_W'(Y_TARGET + 1);
    localparam logic [CNT_W-1:0] TGT = CNT_W'(Y_TARGET);

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } arm_state_t;

    arm_state_t       arm_q [NUM_CH];
    arm_state_t       arm_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0] p_q;
    logic [NUM_CH-1:0] p_d;
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] hit;

    // State registers for all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                arm_q[ch] <= UNARMED;
                cnt_q[ch] <= '0;
            end
            p_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                arm_q[ch] <= arm_d[ch];
                cnt_q[ch] <= cnt_d[ch];
            end
            p_q <= p_d;
        end
    end

    // Next-state logic. match/hit use the pre-update count, and a closing x
    // restarts the count immediately (a coincident y is the new window's first).
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            arm_d[ch] = arm_q[ch];
            cnt_d[ch] = cnt_q[ch];
            p_d[ch]   = p_q[ch];
            match[ch] = 1'b0;
            hit[ch]   = 1'b0;

            if (MODE == 1) begin
                match[ch] = (cnt_q[ch] >= TGT);
            end else begin
                match[ch] = (cnt_q[ch] == TGT);
            end
            hit[ch] = ~clr_i[ch] & (arm_q[ch] == ARMED) & x_i[ch] & match[ch];

            if (clr_i[ch]) begin
                arm_d[ch] = UNARMED;
                cnt_d[ch] = '0;
                p_d[ch]   = 1'b0;
            end else begin
                if (x_i[ch]) begin
                    arm_d[ch] = ARMED;
                    cnt_d[ch] = y_i[ch] ? CNT_W'(1) : '0;
                end else if (y_i[ch]) begin
                    cnt_d[ch] = (cnt_q[ch] == SAT) ? SAT : cnt_q[ch] + CNT_W'(1);
                end

                // A hit wins over a coincident y so back-to-back hits keep p high.
                if (hit[ch]) begin
                    p_d[ch] = 1'b1;
                end else if (y_i[ch]) begin
                    p_d[ch] = 1'b0;
                end
            end
        end
    end

    assign p_o = p_q;

`ifdef MULTI_PULSE_HIT_CNT_EN
    logic [7:0] hit_cnt_q [NUM_CH];
    logic [7:0] hit_cnt_d [NUM_CH];

    // Saturating hit counters, updated on the same edge as p_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hit_cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hit_cnt_q[ch] <= hit_cnt_d[ch];
            end
        end
    end

    always_comb begin
        hit_cnt_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hit_cnt_d[ch] = hit_cnt_q[ch];
            if (clr_i[ch]) begin
                hit_cnt_d[ch] = '0;
            end else if (hit[ch] && (hit_cnt_q[ch] != 8'hFF)) begin
                hit_cnt_d[ch] = hit_cnt_q[ch] + 8'd1;
            end
            hit_cnt_o[8*ch +: 8] = hit_cnt_q[ch];
        end
    end
`endif

endmodule

// File: tb/tb_multi_pulse_window_detect.sv
// ---------------------------------------------------------------------------
// tb_multi_pulse_window_detect
//
// Purpose:
//   Directed self-checking bench. Two instances share the same inputs:
//   dut_ex uses MODE 0 (exact count) and dut_al uses MODE 1 (at-least
//   count). Both use NUM_CH=4 and Y_TARGET=2. Each step drives one clock
//   cycle of inputs, and outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_multi_pulse_window_detect;

    logic       clk;
    logic       reset;
    logic [3:0] x_i;
    logic [3:0] y_i;
    logic [3:0] clr_i;
    logic [3:0] p_ex;
    logic [3:0] p_al;
`ifdef MULTI_PULSE_HIT_CNT_EN
    logic [31:0] hit_cnt_ex;
    logic [31:0] hit_cnt_al;
`endif

    int checks = 0;
    int errors = 0;

    multi_pulse_window_detect #(.NUM_CH(4), .Y_TARGET(2), .MODE(0)) dut_ex (
        .clk       (clk),
        .reset     (reset),
        .x_i       (x_i),
        .y_i       (y_i),
        .clr_i     (clr_i),
`ifdef MULTI_PULSE_HIT_CNT_EN
        .hit_cnt_o (hit_cnt_ex),
`endif
        .p_o       (p_ex)
    );

    multi_pulse_window_detect #(.NUM_CH(4), .Y_TARGET(2), .MODE(1)) dut_al (
        .clk       (clk),
        .reset     (reset),
        .x_i       (x_i),
        .y_i       (y_i),
        .clr_i     (clr_i),
`ifdef MULTI_PULSE_HIT_CNT_EN
        .hit_cnt_o (hit_cnt_al),
`endif
        .p_o       (p_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, waits for the edge, then samples just after it.
    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic [3:0] clr);
        x_i   = x;
        y_i   = y;
        clr_i = clr;
        @(posedge clk);
        #1;
        x_i   = '0;
        y_i   = '0;
        clr_i = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        x_i   = '0;
        y_i   = '0;
        clr_i = '0;
        reset = 1'b1;
        #12;
        checkOutput("reset_p_ex", {28'd0, p_ex}, 32'h0);
        checkOutput("reset_p_al", {28'd0, p_al}, 32'h0);
`ifdef MULTI_PULSE_HIT_CNT_EN
        checkOutput("reset_hitcnt", hit_cnt_ex, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // T1: x, idle, y, idle, y, idle, x on ch0 -> hit
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t1_first_x_no_hit", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t1_before_close", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t1_hit_ex", {28'd0, p_ex}, 32'h1);
        checkOutput("t1_hit_al", {28'd0, p_al}, 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t1_hold", {28'd0, p_ex}, 32'h1);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        checkOutput("t1_fall_on_y", {28'd0, p_ex}, 32'h0);

        // T2: three y pulses -> only at-least mode hits
        applyStimulus(4'b0000, 4'b0000, 4'b0001);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t2_three_y_ex", {28'd0, p_ex}, 32'h0);
        checkOutput("t2_three_y_al", {28'd0, p_al}, 32'h1);
        // Ten y pulses: counter must saturate, not wrap back onto the target
        for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 4'b0001, 4'b0000);
        checkOutput("t2_al_fell", {28'd0, p_al}, 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t2_sat_ex", {28'd0, p_ex}, 32'h0);
        checkOutput("t2_sat_al", {28'd0, p_al}, 32'h1);

        // T3: coincident x+y closes one window and opens the next with cnt=1
        applyStimulus(4'b0000, 4'b0000, 4'b0001);
        checkOutput("t3_clr_al", {28'd0, p_al}, 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("t3_xy_hit", {28'd0, p_ex}, 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t3_hold", {28'd0, p_ex}, 32'h1);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        checkOutput("t3_fall", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t3_second_hit", {28'd0, p_ex}, 32'h1);
        // hit and y in the same cycle keep p high
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("t3_hit_with_y", {28'd0, p_ex}, 32'h1);

        // T4: clear on ch1 beats the closing x, then the next x re-arms only
        applyStimulus(4'b0000, 4'b0000, 4'b0001);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0010);
        checkOutput("t4_clr_wins", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("t4_unarmed_x", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("t4_armed_hit", {28'd0, p_ex}, 32'h2);
        // Asynchronous reset drops p without a clock edge
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_async_reset", {28'd0, p_ex}, 32'h0);
        #3;
        reset = 1'b0;
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("t4_post_reset_unarmed", {28'd0, p_ex}, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b1111);

        // T5: only ch2 gets x; noise y on the other channels never hits
        applyStimulus(4'b0100, 4'($urandom) & 4'b1011, 4'b0000);
        applyStimulus(4'b0000, (4'($urandom) & 4'b1011) | 4'b0100, 4'b0000);
        applyStimulus(4'b0000, 4'($urandom) & 4'b1011, 4'b0000);
        applyStimulus(4'b0000, (4'($urandom) & 4'b1011) | 4'b0100, 4'b0000);
        checkOutput("t5_before_close", {28'd0, p_al}, 32'h0);
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        checkOutput("t5_only_ch2_ex", {28'd0, p_ex}, 32'h4);
        checkOutput("t5_only_ch2_al", {28'd0, p_al}, 32'h4);

`ifdef MULTI_PULSE_HIT_CNT_EN
        // T6: 300 consecutive hits on ch0 saturate the counter, clear zeroes it
        applyStimulus(4'b0000, 4'b0000, 4'b1111);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(4'b0000, 4'b0001, 4'b0000);
            applyStimulus(4'b0001, 4'b0001, 4'b0000);
            if (i == 10) checkOutput("t6_count10", hit_cnt_ex, 32'd10);
        end
        checkOutput("t6_sat_ex", hit_cnt_ex, 32'h0000_00FF);
        checkOutput("t6_sat_al", hit_cnt_al, 32'h0000_00FF);
        applyStimulus(4'b0000, 4'b0000, 4'b0001);
        checkOutput("t6_clr", hit_cnt_ex, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
